tt_gpio_input: RTL and testbench
================================

TT_GPIO_INPUT -- requirements
Module: tt_gpio_input

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops (legal range 2..4).
REQ-002 SHALL have parameter DEB_W, default 8, debounce counter width.
REQ-003 SHALL have port clk  input  1  the only clock.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port pad_in  input  1  raw pad input, asynchronous to clk.
REQ-006 SHALL have port deb_len  input  DEB_W  debounce length, sampled every cycle.
REQ-007 SHALL have port edge_sel  input  2  event select: 00 none, 01 rise, 10 fall, 11 both.
REQ-008 SHALL have port evt_ack  input  1  clears pending and overflow flags.
REQ-009 SHALL have port in_sync  output  1  last synchronizer stage.
REQ-010 SHALL have port in_filt  output  1  debounced level.
REQ-011 SHALL have ports evt_rise and evt_fall  output  1 each  single-cycle edge pulses of in_filt.
REQ-012 SHALL have port evt_pending  output  1  sticky event flag.
REQ-013 SHALL have port evt_ovf  output  1  sticky overflow flag.

Function
REQ-014 SHALL pass pad_in through SYNC_STAGES flops; in_sync follows pad_in after SYNC_STAGES clock edges.
REQ-015 SHALL implement two debounce states, IDLE and SETTLE, with counter cnt.
REQ-016 IDLE: in_sync != in_filt -> SETTLE, cnt<=0; otherwise stay in IDLE.
REQ-017 SETTLE: in_sync == in_filt -> IDLE, no change (glitch rejected); else cnt >= deb_len -> in_filt<=in_sync, IDLE; else cnt<=cnt+1.
REQ-018 SHALL use >= in the SETTLE compare, so a deb_len reduced mid-settle completes on the next cycle; cnt never wraps.
REQ-019 An in_sync level SHALL reach in_filt only after holding for deb_len+2 cycles; latency in_sync->in_filt = deb_len+2 edges; deb_len=0 gives 2.
REQ-020 evt_rise/evt_fall SHALL assert for exactly the first cycle in_filt shows the new value 1/0.
REQ-021 evt_pending SHALL set on an edge matching edge_sel and clear on evt_ack; simultaneous set and ack -> stays 1 (set wins).
REQ-022 evt_ovf SHALL set on a matching edge while evt_pending=1 and evt_ack=0; cleared by evt_ack; a matching edge together with ack -> ovf unchanged.
REQ-023 edge_sel=00 SHALL still generate evt_rise/evt_fall pulses but never set evt_pending.

Reset
REQ-024 rst SHALL clear all synchronizer flops, in_filt, cnt, evt_rise, evt_fall, evt_pending, evt_ovf to 0 and force IDLE in the same edge, including mid-SETTLE.
REQ-025 pad_in high at reset release SHALL yield a normal rising event after the full sync+debounce latency.

Configuration
REQ-026 Macro TT_GPIO_IN_DEBOUNCE_EN defined: debounce per REQ-015..019.
REQ-027 Macro undefined: no counter or FSM; in_filt<=in_sync each cycle (latency 1); deb_len ignored; event logic unchanged.

Structure
REQ-028 Package tt_gpio_pkg SHALL hold the edge_sel encodings (EDGE_NONE/RISE/FALL/BOTH) and the debounce state encoding.
REQ-029 Synchronizer chain SHALL be sub-module tt_gpio_sync (parameter SYNC_STAGES, ports clk, rst, d, q).

Verification (SYNC_STAGES=2, DEB_W=8, macro defined unless stated)
REQ-030 deb_len=3, pad_in 0->1 held -> in_sync=1 after 2 edges, in_filt=1 and evt_rise pulse after 7 edges, evt_pending=1 with edge_sel=01.
REQ-031 deb_len=3, in_sync pulse of 4 cycles -> in_filt stays 0, no events; 5-cycle pulse -> accepted.
REQ-032 edge_sel=01, falling transition -> evt_fall pulse, evt_pending stays 0.
REQ-033 edge_sel=11, two edges without ack -> evt_ovf=1; evt_ack one cycle -> both flags 0 next cycle.
REQ-034 evt_pending=1, evt_ack coincident with new edge -> evt_pending=1, evt_ovf=0; rst mid-SETTLE -> all outputs 0 next cycle.
REQ-035 Macro undefined: 1-cycle pad pulse -> in_filt pulse after 3 edges, evt_rise then evt_fall.

Source files
------------

// File: rtl/tt_gpio_pkg.sv
// Shared encodings for the GPIO input block: edge select codes and debounce FSM states.
package tt_gpio_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_sel_e;

  typedef enum logic {
    DEB_IDLE   = 1'b0,
    DEB_SETTLE = 1'b1
  } deb_state_e;

  // True when a filtered edge is one the software asked to be flagged.
  function automatic logic evt_match(input logic [1:0] sel, input logic rise, input logic fall);
    return (rise && (sel == EDGE_RISE || sel == EDGE_BOTH)) ||
           (fall && (sel == EDGE_FALL || sel == EDGE_BOTH));
  endfunction

endpackage

// File: rtl/tt_gpio_sync.sv
// Multi-flop synchronizer for an asynchronous pad input; q is the last stage.
module tt_gpio_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= '0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/tt_gpio_input.sv
// GPIO input path: synchronizer, optional debounce filter, edge pulses and sticky event flags.
// Define TT_GPIO_IN_DEBOUNCE_EN to build the debounce FSM; otherwise in_filt tracks in_sync by one cycle.
module tt_gpio_input
  import tt_gpio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pad_in,
  input  logic [DEB_W-1:0] deb_len,
  input  logic [1:0]       edge_sel,
  input  logic             evt_ack,
  output logic             in_sync,
  output logic             in_filt,
  output logic             evt_rise,
  output logic             evt_fall,
  output logic             evt_pending,
  output logic             evt_ovf
);

  logic filt_nxt_c;
  logic rise_c;
  logic fall_c;
  logic match_c;

  tt_gpio_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (pad_in),
    .q  (in_sync)
  );

`ifdef TT_GPIO_IN_DEBOUNCE_EN
  deb_state_e       state;
  deb_state_e       state_nxt;
  logic [DEB_W-1:0] cnt;
  logic [DEB_W-1:0] cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DEB_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A new level must persist through the whole settle window; >= lets a shortened deb_len finish at once.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    filt_nxt_c = in_filt;
    case (state)
      DEB_IDLE: begin
        if (in_sync != in_filt) begin
          state_nxt = DEB_SETTLE;
          cnt_nxt   = '0;
        end
      end
      DEB_SETTLE: begin
        if (in_sync == in_filt) begin
          state_nxt = DEB_IDLE;
        end else if (cnt >= deb_len) begin
          filt_nxt_c = in_sync;
          state_nxt  = DEB_IDLE;
        end else begin
          cnt_nxt = cnt + DEB_W'(1);
        end
      end
      default: state_nxt = DEB_IDLE;
    endcase
  end
`else
  logic unused_deb_len;

  assign unused_deb_len = ^deb_len;
  assign filt_nxt_c     = in_sync;
`endif

  assign rise_c  = filt_nxt_c & ~in_filt;
  assign fall_c  = ~filt_nxt_c & in_filt;
  assign match_c = evt_match(edge_sel, rise_c, fall_c);

  // Edge pulses line up with the first cycle in_filt shows its new value; a new event beats ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_filt     <= 1'b0;
      evt_rise    <= 1'b0;
      evt_fall    <= 1'b0;
      evt_pending <= 1'b0;
      evt_ovf     <= 1'b0;
    end else begin
      in_filt     <= filt_nxt_c;
      evt_rise    <= rise_c;
      evt_fall    <= fall_c;
      evt_pending <= match_c | (evt_pending & ~evt_ack);
      if (evt_ack) begin
        evt_ovf <= match_c ? evt_ovf : 1'b0;
      end else if (match_c && evt_pending) begin
        evt_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tt_gpio_input.sv
// Scoreboard bench for tt_gpio_input: directed scenarios plus random pad/ack/edge_sel traffic
// checked cycle by cycle against a run-length reference model.
module tb_tt_gpio_input;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned DEB_W       = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             pad_in;
  logic [DEB_W-1:0] deb_len;
  logic [1:0]       edge_sel;
  logic             evt_ack;
  logic             in_sync;
  logic             in_filt;
  logic             evt_rise;
  logic             evt_fall;
  logic             evt_pending;
  logic             evt_ovf;

  tt_gpio_input #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEB_W      (DEB_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pad_in     (pad_in),
    .deb_len    (deb_len),
    .edge_sel   (edge_sel),
    .evt_ack    (evt_ack),
    .in_sync    (in_sync),
    .in_filt    (in_filt),
    .evt_rise   (evt_rise),
    .evt_fall   (evt_fall),
    .evt_pending(evt_pending),
    .evt_ovf    (evt_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic sync;
    logic filt;
    logic rise;
    logic fall;
    logic pend;
    logic ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference state: pad sample history, filtered level, mismatch run length, flags.
  bit   pipe[$];
  bit   m_sync, m_filt, m_rise, m_fall, m_pend, m_ovf;
  int   run;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0b expected=%0b at t=%0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    pipe.delete();
    for (int i = 0; i < int'(SYNC_STAGES); i++) pipe.push_back(1'b0);
    m_sync = 0; m_filt = 0; m_rise = 0; m_fall = 0; m_pend = 0; m_ovf = 0;
    run = 0;
  endfunction

  // Drive one cycle of inputs, predict the post-edge outputs, then advance past the edge.
  task automatic step(input bit r, input bit p, input int dl, input bit [1:0] sel, input bit ack);
    bit old_sync, new_filt, match;
    exp_t e;
    rst      = r;
    pad_in   = p;
    deb_len  = DEB_W'(dl);
    edge_sel = sel;
    evt_ack  = ack;
    if (r) begin
      model_reset();
    end else begin
      old_sync = m_sync;
      pipe.push_back(p);
      void'(pipe.pop_front());
      m_sync   = pipe[0];
      new_filt = m_filt;
`ifdef TT_GPIO_IN_DEBOUNCE_EN
      // Level is accepted once it has disagreed with in_filt for deb_len+2 consecutive samples.
      if (old_sync != m_filt) begin
        run++;
        if (run >= dl + 2) begin
          new_filt = old_sync;
          run      = 0;
        end
      end else begin
        run = 0;
      end
`else
      new_filt = old_sync;
`endif
      m_rise = new_filt && !m_filt;
      m_fall = !new_filt && m_filt;
      m_filt = new_filt;
      match  = (m_rise && sel[0]) || (m_fall && sel[1]);
      if (ack) m_ovf = match ? m_ovf : 1'b0;
      else if (match && m_pend) m_ovf = 1'b1;
      m_pend = match || (m_pend && !ack);
    end
    e = '{sync: m_sync, filt: m_filt, rise: m_rise, fall: m_fall, pend: m_pend, ovf: m_ovf};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output is compared once per cycle against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("in_sync",     in_sync,     e.sync);
      chk("in_filt",     in_filt,     e.filt);
      chk("evt_rise",    evt_rise,    e.rise);
      chk("evt_fall",    evt_fall,    e.fall);
      chk("evt_pending", evt_pending, e.pend);
      chk("evt_ovf",     evt_ovf,     e.ovf);
    end
  end

  function automatic int latency(input int dl);
`ifdef TT_GPIO_IN_DEBOUNCE_EN
    return int'(SYNC_STAGES) + dl + 2;
`else
    return int'(SYNC_STAGES) + 1 + (dl - dl);
`endif
  endfunction

  initial begin
    int  hold;
    int  dl;
    int  lat;
    bit  lvl;
    bit [1:0] sel;
    rst = 1'b1; pad_in = 1'b0; deb_len = '0; edge_sel = '0; evt_ack = 1'b0;
    model_reset();
    #1;

    repeat (3) step(1, 1, 3, 2'b01, 0);

    // Rising edge with rise select, then falling edge with rise select only.
    repeat (10) step(0, 1, 3, 2'b01, 0);
    step(0, 1, 3, 2'b01, 1);
    repeat (10) step(0, 0, 3, 2'b01, 0);

    // Glitch shorter than the settle window, then one just long enough.
    repeat (4) step(0, 1, 3, 2'b11, 0);
    repeat (8) step(0, 0, 3, 2'b11, 0);
    repeat (5) step(0, 1, 3, 2'b11, 0);
    repeat (8) step(0, 0, 3, 2'b11, 0);
    step(0, 0, 3, 2'b11, 1);

    // Two edges without ack raise overflow; single ack clears both flags.
    repeat (10) step(0, 1, 3, 2'b11, 0);
    repeat (10) step(0, 0, 3, 2'b11, 0);
    step(0, 0, 3, 2'b11, 1);
    repeat (2) step(0, 0, 3, 2'b11, 0);

    // Pending set, then ack exactly on the cycle the next edge lands.
    repeat (10) step(0, 1, 3, 2'b11, 0);
    lat = latency(3);
    step(0, 0, 3, 2'b11, 0);
    repeat (lat - 2) step(0, 0, 3, 2'b11, 0);
    step(0, 0, 3, 2'b11, 1);
    repeat (3) step(0, 0, 3, 2'b11, 0);

    // Reset in the middle of a settle window, pad held high across release.
    repeat (4) step(0, 1, 5, 2'b01, 0);
    step(1, 1, 5, 2'b01, 0);
    repeat (12) step(0, 1, 5, 2'b01, 0);

    // Single-cycle pad pulse.
    step(0, 0, 0, 2'b11, 1);
    repeat (4) step(0, 0, 0, 2'b00, 0);
    step(0, 1, 0, 2'b00, 0);
    repeat (8) step(0, 0, 0, 2'b00, 0);

    // Random traffic.
    dl = 2;
    for (int seg = 0; seg < 400; seg++) begin
      lvl  = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 12);
      sel  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) dl = $urandom_range(0, 6);
      for (int i = 0; i < hold; i++) begin
        if ($urandom_range(0, 9) == 0) dl = $urandom_range(0, 6);
        step(($urandom_range(0, 299) == 0), lvl, dl, sel, ($urandom_range(0, 5) == 0));
      end
    end
    repeat (5) step(0, 0, 0, 2'b00, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
